// File: rtl/sfm_tcdm_lane_sync_if.sv
// Bus bundle for sfm_tcdm_lane_sync: the wide HCI-style port plus the MP independent TCDM lanes.
// slave is the lane synchroniser; master is whatever drives the wide request and answers on the lanes.
interface sfm_tcdm_lane_sync_if #(
    parameter int unsigned MP = 4
);
    logic                in_req_i;
    logic                in_gnt_o;
    logic [31:0]         in_add_i;
    logic                in_wen_i;
    logic [MP*4-1:0]     in_be_i;
    logic [MP*32-1:0]    in_data_i;
    logic                in_r_valid_o;
    logic [MP*32-1:0]    in_r_data_o;
    logic [MP-1:0]       tcdm_req_o;
    logic [MP-1:0]       tcdm_gnt_i;
    logic [MP-1:0][31:0] tcdm_add_o;
    logic [MP-1:0]       tcdm_wen_o;
    logic [MP-1:0][3:0]  tcdm_be_o;
    logic [MP-1:0][31:0] tcdm_data_o;
    logic [MP-1:0][31:0] tcdm_r_data_i;
    logic [MP-1:0]       tcdm_r_valid_i;
    logic                busy_o;
    logic                err_o;
    logic [31:0]         stall_cnt_o;

    modport slave (
        input  in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
        input  tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i,
        output in_gnt_o, in_r_valid_o, in_r_data_o,
        output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
        output busy_o, err_o, stall_cnt_o
    );

    modport master (
        output in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
        output tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i,
        input  in_gnt_o, in_r_valid_o, in_r_data_o,
        input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
        input  busy_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/sfm_tcdm_lane_sync.sv
// Splits one wide TCDM request over MP lanes, tracks per-lane grants, and re-aligns lane responses.
// Optional stall counter enabled by defining SFM_TCDM_STALL_CNT_EN.
module sfm_tcdm_lane_sync #(
    parameter int unsigned MP    = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sfm_tcdm_lane_sync_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [MP-1:0]                  done_mask_q, done_mask_d;
    logic [CW-1:0]                  outst_q, outst_d;
    logic                           err_q, err_d;
    logic                           r_valid_q, r_valid_d;
    logic [MP-1:0][31:0]            r_data_q, r_data_d;
    logic [MP-1:0][DEPTH-1:0][31:0] mem_q, mem_d;
    logic [MP-1:0][PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [MP-1:0][PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [MP-1:0][CW-1:0]          cnt_q, cnt_d;

    logic                credit_ok_c, all_done_c, gnt_c, rd_gnt_c, pop_c;
    logic [MP-1:0]       req_c, lane_gnt_c, lane_rdy_c, enq_c, deq_c, ovf_c;
    logic [MP-1:0][31:0] head_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A wide response in flight this cycle frees its credit for a read arriving now.
    always_comb begin
        credit_ok_c = !bus.in_wen_i || (outst_q < CW'(DEPTH)) || r_valid_q;
        req_c       = '0;
        if (!rst_i && bus.in_req_i && credit_ok_c) begin
            req_c = ~done_mask_q;
        end
        lane_gnt_c = req_c & bus.tcdm_gnt_i;
        all_done_c = &(done_mask_q | lane_gnt_c);
        gnt_c      = !rst_i && bus.in_req_i && credit_ok_c && all_done_c;
        rd_gnt_c   = gnt_c && bus.in_wen_i;
    end

    always_comb begin
        for (int unsigned ii = 0; ii < MP; ii++) begin
            bus.tcdm_add_o[ii]  = bus.in_add_i + (32'(ii) << 2);
            bus.tcdm_be_o[ii]   = bus.in_be_i[4*ii +: 4];
            bus.tcdm_data_o[ii] = bus.in_data_i[32*ii +: 32];
        end
    end

    // Lane data present either in the FIFO or on the wire lets the wide response leave without a bubble.
    always_comb begin
        lane_rdy_c = '0;
        head_c     = '0;
        for (int unsigned ii = 0; ii < MP; ii++) begin
            lane_rdy_c[ii] = (cnt_q[ii] != '0) || bus.tcdm_r_valid_i[ii];
            head_c[ii]     = (cnt_q[ii] != '0) ? mem_q[ii][rd_ptr_q[ii]] : bus.tcdm_r_data_i[ii];
        end
        pop_c = &lane_rdy_c;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        enq_c    = '0;
        deq_c    = '0;
        ovf_c    = '0;
        for (int unsigned ii = 0; ii < MP; ii++) begin
            deq_c[ii] = pop_c && (cnt_q[ii] != '0);
            ovf_c[ii] = bus.tcdm_r_valid_i[ii] && !deq_c[ii] && (cnt_q[ii] == CW'(DEPTH));
            enq_c[ii] = bus.tcdm_r_valid_i[ii] && !ovf_c[ii] && !(pop_c && (cnt_q[ii] == '0));
            if (enq_c[ii]) begin
                mem_d[ii][wr_ptr_q[ii]] = bus.tcdm_r_data_i[ii];
                wr_ptr_d[ii]            = ptr_inc(wr_ptr_q[ii]);
            end
            if (deq_c[ii]) begin
                rd_ptr_d[ii] = ptr_inc(rd_ptr_q[ii]);
            end
            cnt_d[ii] = cnt_q[ii] + CW'(enq_c[ii]) - CW'(deq_c[ii]);
        end
        if (ovf_c != '0) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        done_mask_d = gnt_c ? '0 : (done_mask_q | lane_gnt_c);
        r_valid_d   = pop_c;
        r_data_d    = pop_c ? head_c : r_data_q;
        outst_d     = outst_q;
        if (rd_gnt_c && !r_valid_q) begin
            outst_d = outst_q + CW'(1);
        end else if (!rd_gnt_c && r_valid_q && (outst_q != '0)) begin
            outst_d = outst_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_mask_q <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            done_mask_q <= done_mask_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.tcdm_req_o   = req_c;
    assign bus.tcdm_wen_o   = {MP{bus.in_wen_i}};
    assign bus.in_gnt_o     = gnt_c;
    assign bus.in_r_valid_o = r_valid_q;
    assign bus.in_r_data_o  = r_data_q;
    assign bus.err_o        = err_q;
    assign bus.busy_o       = !rst_i && ((outst_q != '0) || (done_mask_q != '0));

`ifdef SFM_TCDM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the wide request waits for its grant.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.in_req_i && !gnt_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
`else
    assign bus.stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_sfm_tcdm_lane_sync.sv
// Directed bench for sfm_tcdm_lane_sync: inputs change 1 ns after a rising edge, outputs are checked 4 ns later.
module tb_sfm_tcdm_lane_sync;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] stall_exp;

    sfm_tcdm_lane_sync_if #(.MP(4)) bus ();

    sfm_tcdm_lane_sync #(.MP(4), .DEPTH(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef SFM_TCDM_STALL_CNT_EN
        stall_exp = 32'd3;
`else
        stall_exp = 32'd0;
`endif
        rst                = 1'b1;
        bus.in_req_i       = 1'b1;
        bus.in_add_i       = 32'h0;
        bus.in_wen_i       = 1'b1;
        bus.in_be_i        = 16'hFFFF;
        bus.in_data_i      = '0;
        bus.tcdm_gnt_i     = 4'b1111;
        bus.tcdm_r_valid_i = 4'b0000;
        bus.tcdm_r_data_i  = '0;
        tick();
        tick();
        #3;
        chk("rst_lane_req", 128'(bus.tcdm_req_o), 128'h0);
        chk("rst_gnt", 128'(bus.in_gnt_o), 128'h0);
        chk("rst_rvalid", 128'(bus.in_r_valid_o), 128'h0);
        chk("rst_rdata", 128'(bus.in_r_data_o), 128'h0);
        chk("rst_busy", 128'(bus.busy_o), 128'h0);
        chk("rst_err", 128'(bus.err_o), 128'h0);
        chk("rst_stall", 128'(bus.stall_cnt_o), 128'h0);

        // aligned read at 0x100
        tick();
        rst = 1'b0;
        bus.in_req_i = 1'b1; bus.in_wen_i = 1'b1; bus.in_add_i = 32'h100; bus.tcdm_gnt_i = 4'b1111;
        #3;
        chk("al_gnt", 128'(bus.in_gnt_o), 128'h1);
        chk("al_req", 128'(bus.tcdm_req_o), 128'hF);
        chk("al_add0", 128'(bus.tcdm_add_o[0]), 128'h100);
        chk("al_add3", 128'(bus.tcdm_add_o[3]), 128'h10C);
        chk("al_wen", 128'(bus.tcdm_wen_o), 128'hF);
        tick();
        bus.in_req_i = 1'b0; bus.tcdm_gnt_i = 4'b0000;
        bus.tcdm_r_valid_i = 4'b1111;
        bus.tcdm_r_data_i  = 128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000;
        #3;
        chk("al_rv_c1", 128'(bus.in_r_valid_o), 128'h0);
        chk("al_busy_c1", 128'(bus.busy_o), 128'h1);
        tick();
        bus.tcdm_r_valid_i = 4'b0000;
        #3;
        chk("al_rv_c2", 128'(bus.in_r_valid_o), 128'h1);
        chk("al_rdata", 128'(bus.in_r_data_o), 128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000);
        tick();
        #3;
        chk("al_rv_c3", 128'(bus.in_r_valid_o), 128'h0);
        chk("al_busy_c3", 128'(bus.busy_o), 128'h0);

        // staggered write at 0x200
        tick();
        bus.in_req_i = 1'b1; bus.in_wen_i = 1'b0; bus.in_add_i = 32'h200;
        bus.in_data_i = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        bus.in_be_i = 16'hF0F3;
        bus.tcdm_gnt_i = 4'b0101;
        #3;
        chk("sw_req_c0", 128'(bus.tcdm_req_o), 128'hF);
        chk("sw_gnt_c0", 128'(bus.in_gnt_o), 128'h0);
        chk("sw_wen", 128'(bus.tcdm_wen_o), 128'h0);
        chk("sw_data2", 128'(bus.tcdm_data_o[2]), 128'h3333_3333);
        chk("sw_be0", 128'(bus.tcdm_be_o[0]), 128'h3);
        chk("sw_be3", 128'(bus.tcdm_be_o[3]), 128'hF);
        tick();
        bus.tcdm_gnt_i = 4'b0000;
        #3;
        chk("sw_req_c1", 128'(bus.tcdm_req_o), 128'hA);
        chk("sw_gnt_c1", 128'(bus.in_gnt_o), 128'h0);
        chk("sw_busy_c1", 128'(bus.busy_o), 128'h1);
        tick();
        bus.tcdm_gnt_i = 4'b0010;
        #3;
        chk("sw_req_c2", 128'(bus.tcdm_req_o), 128'hA);
        chk("sw_gnt_c2", 128'(bus.in_gnt_o), 128'h0);
        tick();
        bus.tcdm_gnt_i = 4'b1000;
        #3;
        chk("sw_req_c3", 128'(bus.tcdm_req_o), 128'h8);
        chk("sw_gnt_c3", 128'(bus.in_gnt_o), 128'h1);
        tick();
        bus.in_req_i = 1'b0; bus.tcdm_gnt_i = 4'b0000; bus.in_be_i = 16'hFFFF;
        #3;
        chk("sw_stall", 128'(bus.stall_cnt_o), 128'(stall_exp));
        chk("sw_busy_c4", 128'(bus.busy_o), 128'h0);
        chk("sw_req_idle", 128'(bus.tcdm_req_o), 128'h0);

        // credit limit: three back-to-back reads at 0x300
        tick();
        bus.in_req_i = 1'b1; bus.in_wen_i = 1'b1; bus.in_add_i = 32'h300; bus.tcdm_gnt_i = 4'b1111;
        #3;
        chk("cr_gnt_r1", 128'(bus.in_gnt_o), 128'h1);
        tick();
        #3;
        chk("cr_gnt_r2", 128'(bus.in_gnt_o), 128'h1);
        tick();
        #3;
        chk("cr_req_blk_c2", 128'(bus.tcdm_req_o), 128'h0);
        chk("cr_gnt_blk_c2", 128'(bus.in_gnt_o), 128'h0);
        tick();
        bus.tcdm_r_valid_i = 4'b1111;
        bus.tcdm_r_data_i  = 128'h1000_0004_1000_0003_1000_0002_1000_0001;
        #3;
        chk("cr_req_blk_c3", 128'(bus.tcdm_req_o), 128'h0);
        chk("cr_gnt_blk_c3", 128'(bus.in_gnt_o), 128'h0);
        tick();
        bus.tcdm_r_valid_i = 4'b0000;
        #3;
        chk("cr_rv_c4", 128'(bus.in_r_valid_o), 128'h1);
        chk("cr_rdata1", 128'(bus.in_r_data_o), 128'h1000_0004_1000_0003_1000_0002_1000_0001);
        chk("cr_req_c4", 128'(bus.tcdm_req_o), 128'hF);
        chk("cr_gnt_r3", 128'(bus.in_gnt_o), 128'h1);
        tick();
        bus.in_req_i = 1'b0; bus.tcdm_gnt_i = 4'b0000;
        bus.tcdm_r_valid_i = 4'b1111;
        bus.tcdm_r_data_i  = 128'h2000_0004_2000_0003_2000_0002_2000_0001;
        #3;
        chk("cr_busy_c5", 128'(bus.busy_o), 128'h1);
        tick();
        bus.tcdm_r_data_i  = 128'h3000_0004_3000_0003_3000_0002_3000_0001;
        #3;
        chk("cr_rv_c6", 128'(bus.in_r_valid_o), 128'h1);
        chk("cr_rdata2", 128'(bus.in_r_data_o), 128'h2000_0004_2000_0003_2000_0002_2000_0001);
        tick();
        bus.tcdm_r_valid_i = 4'b0000;
        #3;
        chk("cr_rdata3", 128'(bus.in_r_data_o), 128'h3000_0004_3000_0003_3000_0002_3000_0001);
        tick();
        #3;
        chk("cr_busy_end", 128'(bus.busy_o), 128'h0);
        chk("cr_rv_end", 128'(bus.in_r_valid_o), 128'h0);

        // skewed responses: lane 3 lags the others by 4 cycles
        tick();
        bus.in_req_i = 1'b1; bus.in_wen_i = 1'b1; bus.in_add_i = 32'h400; bus.tcdm_gnt_i = 4'b1111;
        #3;
        chk("sk_gnt1", 128'(bus.in_gnt_o), 128'h1);
        tick();
        bus.tcdm_r_valid_i = 4'b0111;
        bus.tcdm_r_data_i  = 128'h0000_0000_5A00_0002_5A00_0001_5A00_0000;
        #3;
        chk("sk_gnt2", 128'(bus.in_gnt_o), 128'h1);
        tick();
        bus.in_req_i = 1'b0; bus.tcdm_gnt_i = 4'b0000;
        bus.tcdm_r_data_i  = 128'h0000_0000_5B00_0002_5B00_0001_5B00_0000;
        tick();
        bus.tcdm_r_valid_i = 4'b0000;
        tick();
        #3;
        chk("sk_rv_wait", 128'(bus.in_r_valid_o), 128'h0);
        tick();
        bus.tcdm_r_valid_i = 4'b1000;
        bus.tcdm_r_data_i  = 128'h5A00_0003_0000_0000_0000_0000_0000_0000;
        #3;
        chk("sk_rv_c5", 128'(bus.in_r_valid_o), 128'h0);
        tick();
        bus.tcdm_r_data_i  = 128'h5B00_0003_0000_0000_0000_0000_0000_0000;
        #3;
        chk("sk_rv_c6", 128'(bus.in_r_valid_o), 128'h1);
        chk("sk_rdata1", 128'(bus.in_r_data_o), 128'h5A00_0003_5A00_0002_5A00_0001_5A00_0000);
        tick();
        bus.tcdm_r_valid_i = 4'b0000;
        #3;
        chk("sk_rv_c7", 128'(bus.in_r_valid_o), 128'h1);
        chk("sk_rdata2", 128'(bus.in_r_data_o), 128'h5B00_0003_5B00_0002_5B00_0001_5B00_0000);
        tick();
        #3;
        chk("sk_rv_c8", 128'(bus.in_r_valid_o), 128'h0);
        chk("sk_err", 128'(bus.err_o), 128'h0);
        chk("sk_busy", 128'(bus.busy_o), 128'h0);

        // overflow: three pushes on lane 0 with the other lanes silent
        tick();
        bus.tcdm_r_valid_i = 4'b0001;
        bus.tcdm_r_data_i  = 128'h0000_0000_0000_0000_0000_0000_0E00_0001;
        tick();
        tick();
        #3;
        chk("ov_err_c2", 128'(bus.err_o), 128'h0);
        tick();
        bus.tcdm_r_valid_i = 4'b0000;
        #3;
        chk("ov_err_c3", 128'(bus.err_o), 128'h1);
        chk("ov_rv", 128'(bus.in_r_valid_o), 128'h0);
        tick();
        tick();
        #3;
        chk("ov_err_sticky", 128'(bus.err_o), 128'h1);

        // reset in the middle of a partially granted write
        tick();
        bus.in_req_i = 1'b1; bus.in_wen_i = 1'b0; bus.in_add_i = 32'h500; bus.tcdm_gnt_i = 4'b0011;
        #3;
        chk("rm_req_c0", 128'(bus.tcdm_req_o), 128'hF);
        chk("rm_gnt_c0", 128'(bus.in_gnt_o), 128'h0);
        tick();
        rst = 1'b1; bus.tcdm_gnt_i = 4'b0000;
        #3;
        chk("rm_req_rst", 128'(bus.tcdm_req_o), 128'h0);
        chk("rm_gnt_rst", 128'(bus.in_gnt_o), 128'h0);
        tick();
        rst = 1'b0; bus.tcdm_gnt_i = 4'b1111;
        #3;
        chk("rm_req_after", 128'(bus.tcdm_req_o), 128'hF);
        chk("rm_gnt_after", 128'(bus.in_gnt_o), 128'h1);
        chk("rm_busy", 128'(bus.busy_o), 128'h0);
        chk("rm_err_clr", 128'(bus.err_o), 128'h0);
        chk("rm_stall_clr", 128'(bus.stall_cnt_o), 128'h0);
        tick();
        bus.in_req_i = 1'b0; bus.tcdm_gnt_i = 4'b0000;
        #3;
        chk("rm_busy_end", 128'(bus.busy_o), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
